// File: rtl/keypad_scan_4x4_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_4x4_pkg;

  localparam int unsigned Rows = 4;
  localparam int unsigned Cols = 4;
  // Row drive value out of reset: row 0 selected (active-low).
  localparam logic [3:0] RowIdle = 4'b1110;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StHeld,
    StRelease
  } state_e;

  // Returns {exactly_one_bit_set, index_of_that_bit}. Index is meaningless unless bit 4 is set.
  function automatic logic [4:0] decode_snapshot(input logic [15:0] snap);
    logic [4:0] n;
    logic [3:0] idx;
    n   = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        n   = n + 5'd1;
        idx = 4'(i);
      end
    end
    return {(n == 5'd1), idx};
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
module keypad_scan_4x4_sync_2ff #(
  parameter int unsigned      Width    = 4,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture; first stage may go metastable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with debounce and single-key reporting.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_4x4 import keypad_scan_4x4_pkg::*; #(
  parameter int unsigned SCAN_DIV       = 27000,
  parameter int unsigned DEBOUNCE_SCANS = 20
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  logic [3:0]      col_sync;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      row_n_q, row_n_d;
  logic [11:0]     snap_q, snap_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_down_q, key_down_d;

  logic            slot_end, eval, hit, held_seen, cnt_done, accept, rep_fire;
  logic [4:0]      dec;
  logic [3:0]      idx;

  keypad_scan_4x4_sync_2ff #(
    .Width    (4),
    .ResetVal (4'b1111)
  ) u_col_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (col_n),
    .q_o   (col_sync)
  );

  assign slot_end  = (32'(div_q) == SCAN_DIV - 32'd1);
  assign eval      = slot_end && (row_n_q == 4'b0111);
  // Row 3 is evaluated straight from the synchronizer, so its bits never need storing.
  assign dec       = decode_snapshot({~col_sync, snap_q});
  assign hit       = dec[4];
  assign idx       = dec[3:0];
  assign held_seen = hit && (idx == key_code_q);
  assign cnt_done  = (32'(cnt_q) + 32'd1 >= DEBOUNCE_SCANS);

  // Row slot timing, row rotation and per-row column capture.
  always_comb begin
    div_d   = div_q + 1'b1;
    row_n_d = row_n_q;
    snap_d  = snap_q;
    if (slot_end) begin
      div_d   = '0;
      row_n_d = {row_n_q[2:0], row_n_q[3]};
      case (row_n_q)
        4'b1110: snap_d[3:0]  = ~col_sync;
        4'b1101: snap_d[7:4]  = ~col_sync;
        4'b1011: snap_d[11:8] = ~col_sync;
        default: ;
      endcase
    end
  end

  // Debounce FSM, advanced once per full scan.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_code_d = key_code_q;
    key_down_d = key_down_q;
    accept     = 1'b0;
    if (eval) begin
      case (state_q)
        StIdle: begin
          if (hit) begin
            cand_d  = idx;
            cnt_d   = CntW'(1);
            state_d = StPress;
            if (DEBOUNCE_SCANS <= 1) accept = 1'b1;
          end
        end
        StPress: begin
          if (!hit) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (idx == cand_q) begin
            if (cnt_done) accept = 1'b1;
            else          cnt_d  = cnt_q + 1'b1;
          end else begin
            cand_d = idx;
            cnt_d  = CntW'(1);
          end
        end
        StHeld: begin
          if (held_seen) begin
            cnt_d = '0;
          end else if (DEBOUNCE_SCANS <= 1) begin
            state_d    = StIdle;
            key_down_d = 1'b0;
            cnt_d      = '0;
          end else begin
            state_d = StRelease;
            cnt_d   = CntW'(1);
          end
        end
        StRelease: begin
          if (held_seen) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d    = StIdle;
            key_down_d = 1'b0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (accept) begin
        key_code_d = idx;
        key_down_d = 1'b1;
        state_d    = StHeld;
        cnt_d      = '0;
      end
    end
  end

  assign key_valid_d = accept | rep_fire;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_armed_q, rep_armed_d;

  // Auto-repeat: first re-issue after REPEAT_DELAY held scans, then every REPEAT_RATE.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if (eval) begin
      if (state_q == StHeld && held_seen) begin
        if (!rep_armed_q && (32'(rep_cnt_q) + 32'd1 >= REPEAT_DELAY)) begin
          rep_fire    = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b1;
        end else if (rep_armed_q && (32'(rep_cnt_q) + 32'd1 >= REPEAT_RATE)) begin
          rep_fire  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else if (state_d == StIdle) begin
        // A bounce through RELEASE keeps the count; only a completed release clears it.
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scanner and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      row_n_q     <= RowIdle;
      snap_q      <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_n_q     <= row_n_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4: keypad matrix model, scan-level vector table,
// reset corner cases and randomized presses against a scan-level reference model.
module tb_keypad_scan_4x4;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned Deb      = 3;
  localparam int unsigned RepDelay = 4;
  localparam int unsigned RepRate  = 2;
  localparam int unsigned ScanClks = 4 * ScanDiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed;

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;

  always #5 clk = ~clk;

  keypad_scan_4x4 #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_SCANS (Deb)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY   (RepDelay),
    .REPEAT_RATE    (RepRate)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Physical keypad: a pressed key shorts its row line to its column line.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~pressed[r*4 +: 4];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- scan-level reference model ----------------
  bit m_held;
  int m_code;
  int m_rep;
  bit m_rel;
  int res_q[$];

  task automatic model_scan(input logic [15:0] m, output bit pulse);
    int  r;
    bit  same;
    r     = ($countones(m) == 1) ? $clog2(m) : -1;
    pulse = 1'b0;
    res_q.push_back(r);
    if (!m_held) begin
      if (res_q.size() > int'(Deb)) void'(res_q.pop_front());
      if (r >= 0 && res_q.size() >= int'(Deb)) begin
        same = 1'b1;
        foreach (res_q[k]) if (res_q[k] != r) same = 1'b0;
        if (same) begin
          m_held = 1'b1;
          m_code = r;
          pulse  = 1'b1;
          m_rep  = 0;
          m_rel  = 1'b0;
          res_q.delete();
        end
      end
    end else if (r == m_code) begin
      res_q.delete();
`ifdef KEYPAD_REPEAT_EN
      if (!m_rel) begin
        m_rep++;
        if (m_rep == int'(RepDelay) ||
            (m_rep > int'(RepDelay) && (m_rep - int'(RepDelay)) % int'(RepRate) == 0))
          pulse = 1'b1;
      end
`endif
      m_rel = 1'b0;
    end else begin
      m_rel = 1'b1;
      if (res_q.size() >= int'(Deb)) begin
        m_held = 1'b0;
        res_q.delete();
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One full scan with a constant key mask; checks row rotation every clock and the
  // outputs produced by this scan's evaluate.
  task automatic run_scan(input logic [15:0] m, input bit e_pulse, input int e_code,
                          input bit e_down, input string tag);
    int         pulses;
    logic [3:0] exp_row;
    pulses  = 0;
    pressed = m;
    for (int i = 0; i < int'(ScanClks); i++) begin
      @(negedge clk);
      cyc++;
      exp_row = 4'hF ^ (4'h1 << (((cyc + 1) / int'(ScanDiv)) % 4));
      check({tag, " row_n"}, int'(row_n), int'(exp_row));
      if (key_valid) pulses++;
    end
    check({tag, " key_valid pulses"}, pulses, int'(e_pulse));
    check({tag, " key_code"}, int'(key_code), e_code);
    check({tag, " key_down"}, int'(key_down), int'(e_down));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " row_n"}, int'(row_n), 4'b1110);
    check({tag, " key_code"}, int'(key_code), 0);
    check({tag, " key_valid"}, int'(key_valid), 0);
    check({tag, " key_down"}, int'(key_down), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
  endtask

  typedef struct {
    logic [15:0] mask;
    bit          pulse;
    int          code;
    bit          down;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] m, input bit p, input int c, input bit d);
    vec_t v;
    v.mask = m; v.pulse = p; v.code = c; v.down = d;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [15:0] k9, k0, k05, k15, k6, mask;
    bit          p, exp_p;
    int          sel;
    k9 = 16'h0200; k0 = 16'h0001; k05 = 16'h0021; k15 = 16'h8000; k6 = 16'h0040;

    // Idle / clean press / release of key 9.
    for (int i = 0; i < 2; i++) add(16'h0, 0, 0, 0);
    add(k9, 0, 0, 0); add(k9, 0, 0, 0); add(k9, 1, 9, 1); add(k9, 0, 9, 1);
    add(0, 0, 9, 1);  add(0, 0, 9, 1);  add(0, 0, 9, 0);  add(0, 0, 9, 0);
    // Key 9 bouncing then stable.
    add(k9, 0, 9, 0); add(0, 0, 9, 0); add(k9, 0, 9, 0); add(0, 0, 9, 0);
    add(k9, 0, 9, 0); add(k9, 0, 9, 0); add(k9, 1, 9, 1);
    add(0, 0, 9, 1);  add(0, 0, 9, 1);  add(0, 0, 9, 0);
    // Keys 0 and 5 together are rejected; dropping 5 accepts key 0.
    for (int i = 0; i < 4; i++) add(k05, 0, 9, 0);
    add(k0, 0, 9, 0); add(k0, 0, 9, 0); add(k0, 1, 0, 1);
    add(0, 0, 0, 1);  add(0, 0, 0, 1);  add(0, 0, 0, 0);

    pressed = '0;
    rst     = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    check_reset_outputs("reset held");
    release_reset();

    foreach (vecs[i]) run_scan(vecs[i].mask, vecs[i].pulse, vecs[i].code, vecs[i].down, "table");

    // Reset mid-debounce.
    run_scan(k15, 0, 0, 0, "k15 scan1");
    run_scan(k15, 0, 0, 0, "k15 scan2");
    tick(6);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst mid-debounce");
    @(negedge clk);
    check_reset_outputs("rst mid-debounce held");
    rst = 1'b0;
    cyc = -1;
    run_scan(k15, 0, 0, 0, "k15 re1");
    run_scan(k15, 0, 0, 0, "k15 re2");
    run_scan(k15, 1, 15, 1, "k15 accept");
    run_scan(k15, 0, 15, 1, "k15 held1");
    run_scan(k15, 0, 15, 1, "k15 held2");
    // Reset mid-HELD.
    tick(9);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst mid-held");
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
    run_scan(k15, 0, 0, 0, "k15 again1");
    run_scan(k15, 0, 0, 0, "k15 again2");
    run_scan(k15, 1, 15, 1, "k15 again accept");
    run_scan(0, 0, 15, 1, "k15 rel1");
    run_scan(0, 0, 15, 1, "k15 rel2");
    run_scan(0, 0, 15, 0, "k15 rel3");

    // Long hold of key 6: auto-repeat only when the feature is built in.
    for (int s = 0; s < 12; s++) begin
      exp_p = (s == 2);
`ifdef KEYPAD_REPEAT_EN
      if (s >= 2 + int'(RepDelay) && (s - 2 - int'(RepDelay)) % int'(RepRate) == 0) exp_p = 1'b1;
`endif
      run_scan(k6, exp_p, (s >= 2) ? 6 : 15, s >= 2, "k6 hold");
    end
    run_scan(0, 0, 6, 1, "k6 rel1");
    run_scan(0, 0, 6, 1, "k6 rel2");
    run_scan(0, 0, 6, 0, "k6 rel3");

    // Randomized presses with persistence so that debounced accepts actually happen.
    m_held = 1'b0; m_code = 6; m_rep = 0; m_rel = 1'b0; res_q.delete();
    mask = '0;
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 4 && sel <= 5) mask = '0;
      else if (sel >= 6 && sel <= 8) mask = 16'h1 << $urandom_range(0, 15);
      else if (sel == 9) mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      model_scan(mask, p);
      run_scan(mask, p, m_code, m_held, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
